// File: rtl/dino_motion_ctrl_if.sv
// Bundle of per-frame inputs from the scrollers/buttons and the values
// handed to the VGA renderer.
//
// Handshake: there is no valid/ready pair. frame_tick is a one-dclk
// qualifier with no backpressure; every other input is sampled only on
// cycles where frame_tick is high, and every output changes only on the
// dclk edge that samples frame_tick high (or on clr).
interface dino_motion_ctrl_if;
  logic       frame_tick;
  logic       jump_btn;
  logic       restart_btn;
  logic [9:0] obstacle_h;
  logic [9:0] obstacle_v;
  logic [7:0] obstacle_width;
  logic [7:0] obstacle_height;
  logic [9:0] enemy_h;
  logic [9:0] enemy_v;
  logic [7:0] enemy_width;
  logic [7:0] enemy_height;

  logic [9:0] dino_h;
  logic [9:0] dino_v;
  logic       alive;
  logic [3:0] score3;
  logic [3:0] score2;
  logic [3:0] score1;
  logic [3:0] score0;
  logic       jumping;
  logic [1:0] state_dbg;

  // Frame source / game logic driver side.
  modport master (
    output frame_tick, jump_btn, restart_btn,
    output obstacle_h, obstacle_v, obstacle_width, obstacle_height,
    output enemy_h, enemy_v, enemy_width, enemy_height,
    input  dino_h, dino_v, alive, score3, score2, score1, score0, jumping,
    input  state_dbg
  );

  // Motion controller side.
  modport slave (
    input  frame_tick, jump_btn, restart_btn,
    input  obstacle_h, obstacle_v, obstacle_width, obstacle_height,
    input  enemy_h, enemy_v, enemy_width, enemy_height,
    output dino_h, dino_v, alive, score3, score2, score1, score0, jumping,
    output state_dbg
  );
endinterface

// File: rtl/dino_motion_ctrl.sv
// Per-frame Dino Run game-state engine: jump physics, collision against
// one obstacle and one enemy, and a 4-digit BCD score. All state moves
// only on frame_tick so the renderer sees stable values during a frame.
module dino_motion_ctrl #(
  parameter int GROUND_V  = 400,
  parameter int DINO_SIZE = 40,
  parameter int JUMP_VEL  = 15,
  parameter int GRAVITY   = 1,
  parameter int SCORE_DIV = 6
) (
  input  logic                dclk,
  input  logic                clr,
  dino_motion_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_GROUND  = 2'd0,
    ST_RISING  = 2'd1,
    ST_FALLING = 2'd2,
    ST_DEAD    = 2'd3
  } state_t;

  // Prescaler is at least 3 bits wide even for tiny dividers.
  localparam int PW = ($clog2(SCORE_DIV) > 3) ? $clog2(SCORE_DIV) : 3;

  localparam logic [9:0]        C_GROUND_V = 10'(GROUND_V);
  localparam logic [5:0]        C_JUMP_VEL = 6'(JUMP_VEL);
  localparam logic [5:0]        C_GRAVITY  = 6'(GRAVITY);
  localparam logic [PW-1:0]     C_PRE_LAST = PW'(SCORE_DIV - 1);
  localparam logic signed [10:0] C_EDGE    = 11'(DINO_SIZE - 1);

  // Bounding-box overlap of one object against the dino square, done in
  // 11-bit signed arithmetic so R-W can go negative without wrapping.
  function automatic logic obj_hit(
    input logic [9:0] r,
    input logic [7:0] w,
    input logic [9:0] t,
    input logic [7:0] hh,
    input logic [9:0] dv
  );
    logic signed [10:0] s_r;
    logic signed [10:0] s_w;
    logic signed [10:0] s_t;
    logic signed [10:0] s_h;
    logic signed [10:0] s_dv;
    s_r  = signed'({1'b0, r});
    s_w  = signed'({3'b000, w});
    s_t  = signed'({1'b0, t});
    s_h  = signed'({3'b000, hh});
    s_dv = signed'({1'b0, dv});
    return (s_r >= 11'sd1) &&
           ((s_r - s_w) <= C_EDGE) &&
           (s_t <= (s_dv + C_EDGE)) &&
           ((s_t + s_h) >= (s_dv + 11'sd1));
  endfunction

  state_t            r_state;
  logic [9:0]        r_dino_v;
  logic [5:0]        r_vel;
  logic [PW-1:0]     r_pre;
  logic [3:0][3:0]   r_score;
  logic              r_alive;
  logic              r_jumping;

  state_t            w_state_nx;
  logic [9:0]        w_dino_v_nx;
  logic [5:0]        w_vel_nx;
  logic [PW-1:0]     w_pre_nx;
  logic [3:0][3:0]   w_score_nx;
  logic              w_alive_nx;
  logic              w_jumping_nx;

  logic [3:0][3:0]   w_score_inc;
  logic              w_hit_obs;
  logic              w_hit_enemy;
  logic              w_collide;
  logic [10:0]       w_dv_sum;
  logic [6:0]        w_vel_up;

  assign w_hit_obs   = obj_hit(bus.obstacle_h, bus.obstacle_width,
                               bus.obstacle_v, bus.obstacle_height, r_dino_v);
  assign w_hit_enemy = obj_hit(bus.enemy_h, bus.enemy_width,
                               bus.enemy_v, bus.enemy_height, r_dino_v);
  assign w_collide   = (r_state != ST_DEAD) && (w_hit_obs || w_hit_enemy);

  assign w_dv_sum = {1'b0, r_dino_v} + {5'b00000, r_vel};
  assign w_vel_up = {1'b0, r_vel} + {1'b0, C_GRAVITY};

  // BCD increment with ripple carry; 9999 rolls over to 0000.
  always_comb begin
    logic v_carry;
    w_score_inc = r_score;
    v_carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v_carry) begin
        if (r_score[i] == 4'd9) begin
          w_score_inc[i] = 4'd0;
        end else begin
          w_score_inc[i] = r_score[i] + 4'd1;
          v_carry        = 1'b0;
        end
      end
    end
  end

  // Next-state and next-register values; nothing moves without frame_tick.
  always_comb begin
    w_state_nx   = r_state;
    w_dino_v_nx  = r_dino_v;
    w_vel_nx     = r_vel;
    w_pre_nx     = r_pre;
    w_score_nx   = r_score;
    w_alive_nx   = r_alive;
    w_jumping_nx = r_jumping;
    if (bus.frame_tick) begin
      if (r_state == ST_DEAD) begin
        if (bus.restart_btn) begin
          w_state_nx   = ST_GROUND;
          w_dino_v_nx  = C_GROUND_V;
          w_vel_nx     = '0;
          w_pre_nx     = '0;
          w_score_nx   = '0;
          w_alive_nx   = 1'b1;
          w_jumping_nx = 1'b0;
        end
      end else if (w_collide) begin
        // Position, velocity and score freeze where the hit happened.
        w_state_nx   = ST_DEAD;
        w_alive_nx   = 1'b0;
        w_jumping_nx = 1'b0;
      end else begin
        case (r_state)
          ST_GROUND: begin
            if (bus.jump_btn) begin
              w_state_nx   = ST_RISING;
              w_vel_nx     = C_JUMP_VEL;
              w_jumping_nx = 1'b1;
            end
          end
          ST_RISING: begin
            w_dino_v_nx = r_dino_v - {4'b0000, r_vel};
            if (r_vel <= C_GRAVITY) begin
              w_vel_nx   = '0;
              w_state_nx = ST_FALLING;
            end else begin
              w_vel_nx = r_vel - C_GRAVITY;
            end
          end
          ST_FALLING: begin
            if (w_dv_sum >= {1'b0, C_GROUND_V}) begin
              // Landing tick; a held jump_btn relaunches only next tick.
              w_dino_v_nx  = C_GROUND_V;
              w_vel_nx     = '0;
              w_state_nx   = ST_GROUND;
              w_jumping_nx = 1'b0;
            end else begin
              w_dino_v_nx = w_dv_sum[9:0];
              w_vel_nx    = (w_vel_up > {1'b0, C_JUMP_VEL}) ? C_JUMP_VEL
                                                            : w_vel_up[5:0];
            end
          end
          default: begin
          end
        endcase
        if (r_pre == C_PRE_LAST) begin
          w_pre_nx   = '0;
          w_score_nx = w_score_inc;
        end else begin
          w_pre_nx = r_pre + PW'(1);
        end
      end
    end
  end

  // State and datapath registers; clr returns everything to the start screen.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      r_state   <= ST_GROUND;
      r_dino_v  <= C_GROUND_V;
      r_vel     <= '0;
      r_pre     <= '0;
      r_score   <= '0;
      r_alive   <= 1'b1;
      r_jumping <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_dino_v  <= w_dino_v_nx;
      r_vel     <= w_vel_nx;
      r_pre     <= w_pre_nx;
      r_score   <= w_score_nx;
      r_alive   <= w_alive_nx;
      r_jumping <= w_jumping_nx;
    end
  end

  assign bus.dino_h    = 10'd0;
  assign bus.dino_v    = r_dino_v;
  assign bus.alive     = r_alive;
  assign bus.jumping   = r_jumping;
  assign bus.score3    = r_score[3];
  assign bus.score2    = r_score[2];
  assign bus.score1    = r_score[1];
  assign bus.score0    = r_score[0];
  assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed bench for dino_motion_ctrl: a per-tick vector table for the jump
// trajectory and score, then hand-written sequences for collisions,
// restart, clr and a fast-scoring instance for BCD wrap.
module tb_dino_motion_ctrl;

  logic dclk;
  logic clr;

  dino_motion_ctrl_if m_if ();
  dino_motion_ctrl_if f_if ();

  dino_motion_ctrl u_dut (
    .dclk (dclk),
    .clr  (clr),
    .bus  (m_if)
  );

  dino_motion_ctrl #(.SCORE_DIV(1)) u_fast (
    .dclk (dclk),
    .clr  (clr),
    .bus  (f_if)
  );

  // ---------------- clock / reset ----------------
  initial dclk = 1'b0;
  always #20 dclk = ~dclk;

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;
  int alive_ticks = 0;

  typedef struct {
    logic       jump;
    logic [9:0] obs_h;
    logic [7:0] obs_w;
    logic [9:0] obs_v;
    logic [7:0] obs_hh;
    logic [9:0] exp_v;
    logic       exp_alive;
    logic       exp_jumping;
    logic [15:0] exp_score;
  } vec_t;

  typedef struct {
    logic       en;
    logic [9:0] r;
    logic [7:0] w;
    logic [9:0] t;
    logic [7:0] hh;
  } obj_t;

  vec_t vecs [96];
  obj_t misses [5];
  obj_t hits [6];
  int   traj [32];
  int   fast_pts [8];

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] m_score();
    return {m_if.score3, m_if.score2, m_if.score1, m_if.score0};
  endfunction

  function automatic logic [15:0] f_score();
    return {f_if.score3, f_if.score2, f_if.score1, f_if.score0};
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_objs(input obj_t o);
    m_if.obstacle_h = 10'd0; m_if.obstacle_width = 8'd0;
    m_if.obstacle_v = 10'd0; m_if.obstacle_height = 8'd0;
    m_if.enemy_h = 10'd0; m_if.enemy_width = 8'd0;
    m_if.enemy_v = 10'd0; m_if.enemy_height = 8'd0;
    if (o.en) begin
      m_if.enemy_h = o.r; m_if.enemy_width = o.w;
      m_if.enemy_v = o.t; m_if.enemy_height = o.hh;
    end else begin
      m_if.obstacle_h = o.r; m_if.obstacle_width = o.w;
      m_if.obstacle_v = o.t; m_if.obstacle_height = o.hh;
    end
  endtask

  task automatic clear_objs();
    obj_t z;
    z = '{en: 1'b0, r: 10'd0, w: 8'd0, t: 10'd0, hh: 8'd0};
    set_objs(z);
  endtask

  // One frame tick; outputs are sampled at the following negedge.
  task automatic tick_main(input logic jump, input logic restart);
    m_if.jump_btn    = jump;
    m_if.restart_btn = restart;
    @(negedge dclk);
    m_if.frame_tick = 1'b1;
    @(negedge dclk);
    m_if.frame_tick  = 1'b0;
    m_if.jump_btn    = 1'b0;
    m_if.restart_btn = 1'b0;
  endtask

  task automatic tick_fast();
    @(negedge dclk);
    f_if.frame_tick = 1'b1;
    @(negedge dclk);
    f_if.frame_tick = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    obj_t o;
    obj_t mid;
    int   idx;

    traj = '{400, 385, 371, 358, 346, 335, 325, 316, 308, 301, 295, 290, 286,
             283, 281, 280, 280, 281, 283, 286, 290, 295, 301, 308, 316, 325,
             335, 346, 358, 371, 385, 400};

    // Ticks 0..31 pulsed jump, 32..63 held jump, 64 relaunch after landing,
    // 65..95 free flight with the obstacle present only while dino_v <= 370.
    for (int t = 0; t < 96; t++) begin
      idx = (t < 32) ? t : ((t < 64) ? t - 32 : t - 64);
      vecs[t].jump   = (t == 0) || (t >= 32 && t <= 64);
      vecs[t].obs_h  = 10'd0;
      vecs[t].obs_w  = 8'd0;
      vecs[t].obs_v  = 10'd0;
      vecs[t].obs_hh = 8'd0;
      if (t >= 65 && traj[idx - 1] <= 370) begin
        vecs[t].obs_h  = 10'd30;
        vecs[t].obs_w  = 8'd20;
        vecs[t].obs_v  = 10'd410;
        vecs[t].obs_hh = 8'd30;
      end
      vecs[t].exp_v       = 10'(traj[idx]);
      vecs[t].exp_alive   = 1'b1;
      vecs[t].exp_jumping = (idx != 31);
      vecs[t].exp_score   = to_bcd((t + 1) / 6);
    end

    misses[0] = '{en: 1'b0, r: 10'd0,  w: 8'd0,  t: 10'd410, hh: 8'd30};
    misses[1] = '{en: 1'b0, r: 10'd60, w: 8'd20, t: 10'd410, hh: 8'd30};
    misses[2] = '{en: 1'b0, r: 10'd30, w: 8'd20, t: 10'd440, hh: 8'd10};
    misses[3] = '{en: 1'b0, r: 10'd30, w: 8'd20, t: 10'd370, hh: 8'd30};
    misses[4] = '{en: 1'b1, r: 10'd60, w: 8'd20, t: 10'd410, hh: 8'd30};

    hits[0] = '{en: 1'b0, r: 10'd30, w: 8'd20, t: 10'd410, hh: 8'd30};
    hits[1] = '{en: 1'b0, r: 10'd49, w: 8'd10, t: 10'd410, hh: 8'd30};
    hits[2] = '{en: 1'b0, r: 10'd30, w: 8'd20, t: 10'd439, hh: 8'd5};
    hits[3] = '{en: 1'b0, r: 10'd30, w: 8'd20, t: 10'd371, hh: 8'd30};
    hits[4] = '{en: 1'b1, r: 10'd10, w: 8'd5,  t: 10'd350, hh: 8'd60};
    hits[5] = '{en: 1'b0, r: 10'd1,  w: 8'd1,  t: 10'd410, hh: 8'd30};

    fast_pts = '{9, 10, 99, 100, 999, 1000, 9999, 10000};

    // Reset
    clr = 1'b1;
    m_if.frame_tick = 1'b0; m_if.jump_btn = 1'b0; m_if.restart_btn = 1'b0;
    f_if.frame_tick = 1'b0; f_if.jump_btn = 1'b0; f_if.restart_btn = 1'b0;
    clear_objs();
    f_if.obstacle_h = 10'd0; f_if.obstacle_width = 8'd0;
    f_if.obstacle_v = 10'd0; f_if.obstacle_height = 8'd0;
    f_if.enemy_h = 10'd0; f_if.enemy_width = 8'd0;
    f_if.enemy_v = 10'd0; f_if.enemy_height = 8'd0;
    repeat (3) @(negedge dclk);
    check("rst_dino_v", 0, 16'(m_if.dino_v), 16'd400);
    check("rst_dino_h", 0, 16'(m_if.dino_h), 16'd0);
    check("rst_alive", 0, 16'(m_if.alive), 16'd1);
    check("rst_jumping", 0, 16'(m_if.jumping), 16'd0);
    check("rst_score", 0, m_score(), 16'h0000);
    check("rst_state", 0, 16'(m_if.state_dbg), 16'd0);
    check("rst_fast_score", 0, f_score(), 16'h0000);
    clr = 1'b0;
    @(negedge dclk);

    // Table-driven trajectory / score vectors
    for (int t = 0; t < 96; t++) begin
      m_if.obstacle_h      = vecs[t].obs_h;
      m_if.obstacle_width  = vecs[t].obs_w;
      m_if.obstacle_v      = vecs[t].obs_v;
      m_if.obstacle_height = vecs[t].obs_hh;
      tick_main(vecs[t].jump, 1'b0);
      check("vec_dino_v", t, 16'(m_if.dino_v), 16'(vecs[t].exp_v));
      check("vec_alive", t, 16'(m_if.alive), 16'(vecs[t].exp_alive));
      check("vec_jumping", t, 16'(m_if.jumping), 16'(vecs[t].exp_jumping));
      check("vec_score", t, m_score(), vecs[t].exp_score);
    end
    clear_objs();
    alive_ticks = 96;

    // Boundary misses while standing
    for (int i = 0; i < 5; i++) begin
      set_objs(misses[i]);
      tick_main(1'b0, 1'b0);
      alive_ticks++;
      check("miss_alive", i, 16'(m_if.alive), 16'd1);
    end
    clear_objs();
    check("miss_score", 0, m_score(), to_bcd(alive_ticks / 6));
    check("miss_dino_v", 0, 16'(m_if.dino_v), 16'd400);

    // Ground collision, frozen while dead, restart ignores same-tick hit
    set_objs(hits[0]);
    tick_main(1'b0, 1'b0);
    check("hit_alive", 0, 16'(m_if.alive), 16'd0);
    check("hit_state", 0, 16'(m_if.state_dbg), 16'd3);
    check("hit_score", 0, m_score(), to_bcd(alive_ticks / 6));
    clear_objs();
    for (int i = 0; i < 3; i++) begin
      tick_main(1'b1, 1'b0);
      check("dead_dino_v", i, 16'(m_if.dino_v), 16'd400);
      check("dead_state", i, 16'(m_if.state_dbg), 16'd3);
      check("dead_score", i, m_score(), to_bcd(alive_ticks / 6));
      check("dead_jumping", i, 16'(m_if.jumping), 16'd0);
    end
    set_objs(hits[0]);
    tick_main(1'b0, 1'b1);
    alive_ticks = 0;
    check("restart_alive", 0, 16'(m_if.alive), 16'd1);
    check("restart_score", 0, m_score(), 16'h0000);
    check("restart_dino_v", 0, 16'(m_if.dino_v), 16'd400);
    check("restart_state", 0, 16'(m_if.state_dbg), 16'd0);
    clear_objs();
    for (int i = 1; i <= 6; i++) begin
      tick_main(1'b0, 1'b0);
      check("prescale_score", i, m_score(), (i == 6) ? 16'h0001 : 16'h0000);
    end

    // Boundary hits (obstacle and enemy), each followed by a restart
    for (int i = 1; i < 6; i++) begin
      set_objs(hits[i]);
      tick_main(1'b0, 1'b0);
      check("edge_hit_alive", i, 16'(m_if.alive), 16'd0);
      clear_objs();
      tick_main(1'b0, 1'b1);
      check("edge_restart_alive", i, 16'(m_if.alive), 16'd1);
    end

    // Mid-air hit freezes the dino where it is
    tick_main(1'b1, 1'b0);
    tick_main(1'b0, 1'b0);
    check("air_pre_dino_v", 0, 16'(m_if.dino_v), 16'd385);
    mid = '{en: 1'b0, r: 10'd30, w: 8'd20, t: 10'd400, hh: 8'd20};
    set_objs(mid);
    tick_main(1'b0, 1'b0);
    check("air_hit_dino_v", 0, 16'(m_if.dino_v), 16'd385);
    check("air_hit_state", 0, 16'(m_if.state_dbg), 16'd3);
    check("air_hit_jumping", 0, 16'(m_if.jumping), 16'd0);
    clear_objs();
    tick_main(1'b0, 1'b0);
    check("air_dead_dino_v", 0, 16'(m_if.dino_v), 16'd385);
    tick_main(1'b0, 1'b1);
    check("air_restart_dino_v", 0, 16'(m_if.dino_v), 16'd400);

    // Idle cycles without a tick, then clr mid-jump
    tick_main(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick_main(1'b0, 1'b0);
    check("pre_clr_dino_v", 0, 16'(m_if.dino_v), 16'd325);
    check("pre_clr_score", 0, m_score(), 16'h0001);
    repeat (5) @(negedge dclk);
    check("no_tick_dino_v", 0, 16'(m_if.dino_v), 16'd325);
    @(posedge dclk);
    #5 clr = 1'b1;
    #1;
    check("clr_dino_v", 0, 16'(m_if.dino_v), 16'd400);
    check("clr_alive", 0, 16'(m_if.alive), 16'd1);
    check("clr_jumping", 0, 16'(m_if.jumping), 16'd0);
    check("clr_score", 0, m_score(), 16'h0000);
    check("clr_state", 0, 16'(m_if.state_dbg), 16'd0);
    @(negedge dclk);
    clr = 1'b0;

    // clr while dead
    o = hits[0];
    set_objs(o);
    tick_main(1'b0, 1'b0);
    check("clr_dead_pre", 0, 16'(m_if.alive), 16'd0);
    clear_objs();
    #7 clr = 1'b1;
    #1;
    check("clr_dead_alive", 0, 16'(m_if.alive), 16'd1);
    check("clr_dead_state", 0, 16'(m_if.state_dbg), 16'd0);
    @(negedge dclk);
    clr = 1'b0;

    // Fast instance: one score step per tick, wraps 9999 -> 0000
    idx = 0;
    for (int n = 1; n <= 10000; n++) begin
      tick_fast();
      if (idx < 8 && n == fast_pts[idx]) begin
        check("fast_score", n, f_score(), to_bcd(n % 10000));
        idx++;
      end
    end
    check("fast_alive", 0, 16'(f_if.alive), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
